// File: rtl/cache_refill_ctrl.sv
// Blocking cache refill controller: zero-stall read hits, 4-word block refill on a miss,
// write-through/no-allocate writes, saturating hit/miss statistics.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_rd_req,
    input  logic                    cpu_wr_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_ready,
    output logic                    cpu_stall,
    output logic                    cache_rd_en,
    output logic                    cache_wr_en,
    output logic                    cache_invalid,
    output logic [ADDR_WIDTH-1:0]   cache_addr,
    output logic [4*DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0]   cache_rdata,
    input  logic                    cache_hit,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
);

    typedef enum logic [2:0] {StIdle, StRefill, StFill, StWrite, StRespond} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [4*DATA_WIDTH-1:0] buf_q, buf_d;
    logic                    is_rd_q, is_rd_d;
    logic [15:0]             hit_cnt_q, hit_cnt_d;
    logic [15:0]             miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            off_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            is_rd_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            is_rd_q    <= is_rd_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        is_rd_d    = is_rd_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_wr_req) begin
                    addr_d  = cpu_addr;
                    data_d  = cpu_wdata;
                    is_rd_d = 1'b0;
                    state_d = StWrite;
                end else if (cpu_rd_req) begin
                    if (cache_hit) begin
                        hit_cnt_d = (hit_cnt_q != 16'hFFFF) ? hit_cnt_q + 16'd1 : hit_cnt_q;
                    end else begin
                        miss_cnt_d = (miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
                        addr_d     = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        off_d      = cpu_addr[1:0];
                        cnt_d      = 2'd0;
                        is_rd_d    = 1'b1;
                        state_d    = StRefill;
                    end
                end
            end
            StRefill: begin
                if (mem_ack) begin
                    buf_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = StFill;
                end
            end
            StFill:    state_d = StRespond;
            StWrite:   if (mem_ack) state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_rdata     = '0;
        cpu_ready     = 1'b0;
        cpu_stall     = 1'b0;
        cache_rd_en   = 1'b0;
        cache_wr_en   = 1'b0;
        cache_invalid = 1'b0;
        cache_addr    = '0;
        cache_wdata   = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (state_q)
            StIdle: begin
                // Idle outputs follow the request inputs, so silence them while reset is held.
                if (!reset) begin
                    if (cpu_wr_req) begin
                        cache_invalid = 1'b1;
                        cache_addr    = cpu_addr;
                        cpu_stall     = 1'b1;
                    end else if (cpu_rd_req) begin
                        cache_rd_en = 1'b1;
                        cache_addr  = cpu_addr;
                        if (cache_hit) begin
                            cpu_ready = 1'b1;
                            cpu_rdata = cache_rdata;
                        end else begin
                            cpu_stall = 1'b1;
                        end
                    end
                end
            end
            StRefill: begin
                mem_req   = 1'b1;
                mem_addr  = addr_q + ADDR_WIDTH'(cnt_q);
                cpu_stall = 1'b1;
            end
            StFill: begin
                cache_wr_en = 1'b1;
                cache_addr  = addr_q;
                cache_wdata = buf_q;
                cpu_stall   = 1'b1;
            end
            StWrite: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                cpu_stall = 1'b1;
            end
            StRespond: begin
                cpu_ready = 1'b1;
                if (is_rd_q) cpu_rdata = buf_q[off_q*DATA_WIDTH +: DATA_WIDTH];
            end
            default: ;
        endcase
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width; one cache block is 4 words.
REQ-003 SHALL have ports: clk input 1, the single clock.
REQ-004 reset input 1, asynchronous active-high reset.
REQ-005 cpu_rd_req input 1, CPU read request, held until cpu_ready.
REQ-006 cpu_wr_req input 1, CPU write request, held until cpu_ready.
REQ-007 cpu_addr input ADDR_WIDTH, request address; bits [1:0] are word offset.
REQ-008 cpu_wdata input DATA_WIDTH, write data.
REQ-009 cpu_rdata output DATA_WIDTH, read data, valid when cpu_ready=1 on a read.
REQ-010 cpu_ready output 1, one-cycle completion pulse.
REQ-011 cpu_stall output 1, high while a request is outstanding and not completing.
REQ-012 cache_rd_en, cache_wr_en, cache_invalid output 1 each, cache control strobes.
REQ-013 cache_addr output ADDR_WIDTH, cache lookup/fill address.
REQ-014 cache_wdata output 4*DATA_WIDTH, fill block; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 cache_rdata input DATA_WIDTH, and cache_hit input 1; both combinational from cache_addr/cache_rd_en.
REQ-016 mem_req, mem_we output 1 each; mem_addr output ADDR_WIDTH; mem_wdata output DATA_WIDTH.
REQ-017 mem_ack input 1, and mem_rdata input DATA_WIDTH, valid in the mem_ack cycle.
REQ-018 hit_count, miss_count output 16 each, statistics counters.

Function
REQ-019 SHALL implement FSM states IDLE, REFILL, FILL, WRITE, RESPOND.
REQ-020 IDLE, cpu_wr_req=1 (priority over cpu_rd_req): cache_invalid=1 and cache_addr=cpu_addr combinationally; latch addr and data; next state WRITE.
REQ-021 IDLE, cpu_rd_req=1 only: cache_rd_en=1, cache_addr=cpu_addr combinationally.
REQ-022 On cache_hit=1: same-cycle cpu_ready=1, cpu_rdata=cache_rdata, hit_count+1; stay IDLE (0-cycle-stall hit).
REQ-023 On cache_hit=0: miss_count+1; latch block address (cpu_addr with [1:0]=0) and offset; clear 2-bit word counter; next state REFILL.
REQ-024 REFILL: mem_req=1, mem_we=0, mem_addr=block address + counter; on mem_ack capture mem_rdata into buffer word [counter] and increment.
REQ-025 REFILL: ack with counter=3 SHALL go to FILL; mem_req SHALL stay high between acks; no cycle limit on ack wait.
REQ-026 FILL: exactly one cycle with cache_wr_en=1, cache_addr=block address, cache_wdata=buffer; next state RESPOND.
REQ-027 WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values until mem_ack; then RESPOND (write-through, no-allocate).
REQ-028 RESPOND: cpu_ready=1 for one cycle; on read, cpu_rdata=buffer[latched offset] (registered); next state IDLE.
REQ-029 cpu_stall=1 in REFILL, FILL, WRITE, and in IDLE for a miss or write acceptance cycle; 0 otherwise.
REQ-030 Read miss latency: 4 ack cycles + FILL + RESPOND; minimum 7 cycles from request with zero-wait memory ack.
REQ-031 Counters SHALL saturate at 16'hFFFF.
REQ-032 Outputs not driven by the current state SHALL be 0; cache_wdata SHALL be 0 outside FILL.
REQ-033 mem_ack outside REFILL/WRITE SHALL be ignored; request inputs outside IDLE SHALL be ignored.

Reset
REQ-034 reset=1 SHALL asynchronously force IDLE, counters, buffer, latches, word counter, and all outputs to 0, including mid-REFILL; a partially fetched block is discarded and never written into the cache.
REQ-035 After reset release, the first request SHALL be accepted in the first clk edge cycle with reset low.

Verification
REQ-036 Reset, read 0x0000_0012 with cache_hit=1, cache_rdata=8'h5A -> same-cycle cpu_ready=1, cpu_rdata=8'h5A, hit_count=1, no mem_req.
REQ-037 Read 0x0000_0106 miss, memory returns 11,22,33,44 at addresses 0x104..0x107, zero wait -> one FILL with cache_wdata=32'h44332211, cache_addr=0x104, then cpu_rdata=8'h33, miss_count=1, ready at cycle 7.
REQ-038 Write 0x0000_0040 data 8'hC3 with 3-cycle ack delay -> cache_invalid pulse at acceptance, mem_we=1 held 3 cycles with mem_addr=0x40, mem_wdata=8'hC3, then cpu_ready; no cache_wr_en.
REQ-039 Simultaneous rd and wr requests at 0x80 -> write path taken, cache_rd_en stays 0.
REQ-040 Assert reset after second refill ack -> all outputs 0 immediately, no cache_wr_en; a new read miss refetches all 4 words from offset 0.
REQ-041 Force hit_count to 16'hFFFE, issue 3 hits -> hit_count saturates at 16'hFFFF.
